// File: rtl/quad_velocity_pkg.sv
// Shared definitions for the quadrature velocity stage: direction encoding,
// symmetric saturation limits and FSM state encoding.
package quad_velocity_pkg;

  localparam logic DIR_FWD = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Symmetric limits: the most negative two's-complement code is never produced.
  function automatic int vel_max(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  function automatic int vel_min(input int width);
    return -vel_max(width);
  endfunction

endpackage

// File: rtl/hba_tick_gen.sv
// Prescaler producing a one-cycle tick every PRESCALE cycles while enabled;
// held at zero whenever the enable is low.
module hba_tick_gen #(
  parameter int PRESCALE = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!en) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = en && (count == LAST);

endmodule

// File: rtl/quad_velocity.sv
// Signed encoder velocity: net decoder steps over a window of prescaled ticks,
// with symmetric saturation and a stall detector.
module quad_velocity
  import quad_velocity_pkg::*;
#(
  parameter int   PRESCALE      = 50000,
  parameter int   WIN_WIDTH     = 8,
  parameter int   VEL_WIDTH     = 16,
  parameter int   STALL_WINDOWS = 4,
  parameter logic FWD           = DIR_FWD
) (
  input  logic                        hba_clk,
  input  logic                        hba_reset,
  input  logic                        en,
  input  logic [WIN_WIDTH-1:0]        window_ticks,
  input  logic                        pulse_in,
  input  logic                        dir_in,
  output logic signed [VEL_WIDTH-1:0] velocity,
  output logic                        vel_valid,
  output logic                        vel_sat,
  output logic                        stalled
);

  localparam logic signed [VEL_WIDTH-1:0] VEL_MAX = VEL_WIDTH'(vel_max(VEL_WIDTH));
  localparam logic signed [VEL_WIDTH-1:0] VEL_MIN = VEL_WIDTH'(vel_min(VEL_WIDTH));
  localparam logic signed [VEL_WIDTH-1:0] ONE     = VEL_WIDTH'(1);
  localparam int SW = (STALL_WINDOWS > 1) ? $clog2(STALL_WINDOWS + 1) : 1;
  localparam logic [SW-1:0] STALL_MAX = SW'(STALL_WINDOWS);

  state_t state, state_next;

  logic [WIN_WIDTH-1:0]        win_len;
  logic [WIN_WIDTH-1:0]        win_cnt;
  logic [WIN_WIDTH-1:0]        win_len_sample;
  logic signed [VEL_WIDTH-1:0] acc, acc_next;
  logic                        sat, sat_next;
  logic [SW-1:0]               stall_cnt, stall_next;
  logic                        run;
  logic                        tick;
  logic                        boundary;

  hba_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk  (hba_clk),
    .rst  (hba_reset),
    .en   (state == ST_RUN),
    .tick (tick)
  );

  always_ff @(posedge hba_clk or posedge hba_reset) begin
    if (hba_reset) state <= ST_IDLE;
    else           state <= state_next;
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (en)  state_next = ST_RUN;
      ST_RUN:  if (!en) state_next = ST_IDLE;
      default:          state_next = ST_IDLE;
    endcase
  end

  assign run            = (state == ST_RUN) && en;
  assign boundary       = run && tick && (win_cnt == win_len - 1'b1);
  assign win_len_sample = (window_ticks == '0) ? WIN_WIDTH'(1) : window_ticks;

  // Saturating step; a clipped step marks the window as saturated.
  always_comb begin
    acc_next = acc;
    sat_next = sat;
    if (pulse_in) begin
      if (dir_in == FWD) begin
        if (acc == VEL_MAX) sat_next = 1'b1;
        else                acc_next = acc + ONE;
      end else begin
        if (acc == VEL_MIN) sat_next = 1'b1;
        else                acc_next = acc - ONE;
      end
    end
  end

  always_comb begin
    stall_next = '0;
    if (acc_next == '0) begin
      stall_next = (stall_cnt == STALL_MAX) ? stall_cnt : stall_cnt + 1'b1;
    end
  end

  always_ff @(posedge hba_clk or posedge hba_reset) begin
    if (hba_reset) begin
      win_len   <= '0;
      win_cnt   <= '0;
      acc       <= '0;
      sat       <= 1'b0;
      stall_cnt <= '0;
      velocity  <= '0;
      vel_valid <= 1'b0;
      vel_sat   <= 1'b0;
      stalled   <= 1'b0;
    end else begin
      vel_valid <= 1'b0;
      if (!run) begin
        // Loading every idle cycle leaves the value sampled on entry to RUN.
        win_cnt <= '0;
        acc     <= '0;
        sat     <= 1'b0;
        win_len <= win_len_sample;
      end else if (boundary) begin
        win_cnt   <= '0;
        win_len   <= win_len_sample;
        acc       <= '0;
        sat       <= 1'b0;
        velocity  <= acc_next;
        vel_sat   <= sat_next;
        vel_valid <= 1'b1;
        stall_cnt <= stall_next;
        stalled   <= (stall_next == STALL_MAX);
      end else begin
        acc <= acc_next;
        sat <= sat_next;
        if (tick) win_cnt <= win_cnt + 1'b1;
      end
    end
  end

endmodule
